// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared constants for the echo parameter control path
package echo_pkg;

    localparam int DLY_W = 15;
    localparam int ATT_W = 16;

    localparam int unsigned ATT_MAX = 32767;

    localparam logic [7:0] CMD_DLY_INC = 8'h11;
    localparam logic [7:0] CMD_DLY_DEC = 8'h12;
    localparam logic [7:0] CMD_ATT_INC = 8'h19;
    localparam logic [7:0] CMD_ATT_DEC = 8'h1A;
    localparam logic [7:0] CMD_DEFAULT = 8'h1F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

endpackage

// File: rtl/echo_param_ctrl_sync.sv
// rtl/echo_param_ctrl_sync.sv - two-flop synchroniser with asynchronous active-low reset
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/echo_param_ctrl.sv
// rtl/echo_param_ctrl.sv - UART command decoder and req/ack publisher of delay/attenuation
module echo_param_ctrl
    import echo_pkg::*;
#(
    parameter int unsigned DELAY_DEF  = 7998,
    parameter int unsigned DELAY_STEP = 1000,
    parameter int unsigned DELAY_MIN  = 998,
    parameter int unsigned DELAY_MAX  = 16382,
    parameter int unsigned ATT_DEF    = 32767,
    parameter int unsigned ATT_STEP   = 20,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    input  logic             cfg_ack,
    output logic             cfg_req,
    output logic [DLY_W-1:0] cfg_delay,
    output logic [ATT_W-1:0] cfg_atten,
    output logic             busy,
    output logic             timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic             ack_s;
    logic [1:0]       state, state_nxt;
    logic             pending, pending_nxt;
    logic             req_nxt, terr_nxt, load;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic [DLY_W-1:0] sh_delay, sh_delay_nxt;
    logic [ATT_W-1:0] sh_atten, sh_atten_nxt;
    logic             cmd_hit;
    logic [16:0]      dly_sum, att_sum;

    sync_2ff #(.WIDTH(1)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cfg_ack),
        .q     (ack_s)
    );

    // Sums are formed 17 bits wide so the bound test sees any carry before truncation.
    assign dly_sum = {2'b00, sh_delay} + 17'(DELAY_STEP);
    assign att_sum = {1'b0, sh_atten} + 17'(ATT_STEP);

    always_comb begin
        sh_delay_nxt = sh_delay;
        sh_atten_nxt = sh_atten;
        cmd_hit      = 1'b0;
        if (cmd_valid) begin
            case (cmd_data)
                CMD_DLY_INC: begin
                    cmd_hit      = 1'b1;
                    sh_delay_nxt = (dly_sum > 17'(DELAY_MAX)) ? DLY_W'(DELAY_MAX) : dly_sum[DLY_W-1:0];
                end
                CMD_DLY_DEC: begin
                    cmd_hit      = 1'b1;
                    sh_delay_nxt = ({2'b00, sh_delay} < 17'(DELAY_MIN + DELAY_STEP)) ?
                                   DLY_W'(DELAY_MIN) : sh_delay - DLY_W'(DELAY_STEP);
                end
                CMD_ATT_INC: begin
                    cmd_hit      = 1'b1;
                    sh_atten_nxt = (att_sum > 17'(ATT_MAX)) ? ATT_W'(ATT_MAX) : att_sum[ATT_W-1:0];
                end
                CMD_ATT_DEC: begin
                    cmd_hit      = 1'b1;
                    sh_atten_nxt = ({1'b0, sh_atten} < 17'(ATT_STEP)) ?
                                   '0 : sh_atten - ATT_W'(ATT_STEP);
                end
                CMD_DEFAULT: begin
                    cmd_hit      = 1'b1;
                    sh_delay_nxt = DLY_W'(DELAY_DEF);
                    sh_atten_nxt = ATT_W'(ATT_DEF);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        req_nxt     = cfg_req;
        tmo_nxt     = tmo;
        terr_nxt    = timeout_err;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                // A stale ack from an aborted handshake holds us here until it clears.
                if (pending && !ack_s) begin
                    load        = 1'b1;
                    req_nxt     = 1'b1;
                    pending_nxt = 1'b0;
                    tmo_nxt     = '0;
                    state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    tmo_nxt   = '0;
                    state_nxt = ST_REL;
                end else if (tmo == TMO_W'(TIMEOUT)) begin
                    terr_nxt  = 1'b1;
                    req_nxt   = 1'b0;
                    tmo_nxt   = '0;
                    state_nxt = ST_REL;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_nxt = ST_IDLE;
                end else if (tmo == TMO_W'(TIMEOUT)) begin
                    terr_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
        // A command on the launch edge survives the clear, forcing a follow-up handshake.
        if (cmd_hit) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_delay    <= DLY_W'(DELAY_DEF);
            sh_atten    <= ATT_W'(ATT_DEF);
            cfg_delay   <= DLY_W'(DELAY_DEF);
            cfg_atten   <= ATT_W'(ATT_DEF);
            cfg_req     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 1'b1;
            state       <= ST_IDLE;
            tmo         <= '0;
        end else begin
            sh_delay    <= sh_delay_nxt;
            sh_atten    <= sh_atten_nxt;
            cfg_req     <= req_nxt;
            timeout_err <= terr_nxt;
            pending     <= pending_nxt;
            state       <= state_nxt;
            tmo         <= tmo_nxt;
            busy        <= (state_nxt != ST_IDLE) | pending_nxt;
            if (load) begin
                cfg_delay <= sh_delay;
                cfg_atten <= sh_atten;
            end
        end
    end

endmodule

// File: tb/tb_echo_param_ctrl.sv
// tb/tb_echo_param_ctrl.sv - randomized scoreboard bench for echo_param_ctrl
module tb_echo_param_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cfg_ack = 1'b0;
    logic        cfg_req;
    logic [14:0] cfg_delay;
    logic [15:0] cfg_atten;
    logic        busy;
    logic        timeout_err;

    typedef struct {
        int dly;
        int att;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nfail = 0;
    int   m_delay = 7998;
    int   m_atten = 32767;
    int   req_rises = 0;
    int   ack_delay = 4;
    bit   ack_stuck = 1'b0;

    echo_param_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cfg_ack     (cfg_ack),
        .cfg_req     (cfg_req),
        .cfg_delay   (cfg_delay),
        .cfg_atten   (cfg_atten),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    // sck-side responder: follows cfg_req after ack_delay cycles
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_stuck) begin
                cfg_ack = 1'b0;
                cnt = 0;
            end else if (cfg_req !== cfg_ack) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cfg_ack = cfg_req;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor: published values must hold while req is high; final set checked when busy falls
    initial begin
        logic        prev_busy, prev_req;
        logic [14:0] pd;
        logic [15:0] pa;
        exp_t        e;
        prev_busy = 1'b0;
        prev_req = 1'b0;
        pd = '0;
        pa = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (cfg_req && prev_req) begin
                    nvec++;
                    if (cfg_delay !== pd || cfg_atten !== pa) begin
                        nfail++;
                        $display("FAIL cfg_stable: delay %0d atten %0d, required %0d %0d", cfg_delay, cfg_atten, pd, pa);
                    end
                end
                if (cfg_req && !prev_req) req_rises++;
                if (prev_busy && !busy) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL sb_unexpected: busy fell with no expectation queued");
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(cfg_delay) != e.dly || int'(cfg_atten) != e.att) begin
                            nfail++;
                            $display("FAIL sb_publish: delay %0d atten %0d, required %0d %0d",
                                     cfg_delay, cfg_atten, e.dly, e.att);
                        end
                    end
                end
                prev_busy = busy;
                prev_req = cfg_req;
                pd = cfg_delay;
                pa = cfg_atten;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void model_apply(input logic [7:0] b);
        case (b)
            8'h11: m_delay = (m_delay + 1000 > 16382) ? 16382 : m_delay + 1000;
            8'h12: m_delay = (m_delay - 1000 < 998) ? 998 : m_delay - 1000;
            8'h19: m_atten = (m_atten + 20 > 32767) ? 32767 : m_atten + 20;
            8'h1A: m_atten = (m_atten - 20 < 0) ? 0 : m_atten - 20;
            8'h1F: begin
                m_delay = 7998;
                m_atten = 32767;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] rand_invalid();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h11 || b == 8'h12 || b == 8'h19 || b == 8'h1A || b == 8'h1F);
        return b;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = b;
        model_apply(b);
    endtask

    task automatic quiet();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_model();
        exp_t e;
        e.dly = m_delay;
        e.att = m_atten;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            nvec++;
            nfail++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, bound);
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input string name, input int bound);
        int n;
        n = 0;
        while (!cfg_req && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_req) begin
            nvec++;
            nfail++;
            $display("FAIL %s: cfg_req still 0 after %0d cycles, required 1", name, bound);
        end
    endtask

    task automatic burst(input logic [7:0] b, input int len);
        for (int i = 0; i < len; i++) send(b);
        quiet();
        push_model();
    endtask

    // valid commands at most 4 cycles apart so the whole burst coalesces into one final publish
    task automatic rand_burst(input int len);
        int r, g;
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 8);
            case (r)
                0, 1: b = 8'h11;
                2, 3: b = 8'h12;
                4, 5: b = 8'h19;
                6, 7: b = 8'h1A;
                default: b = 8'h1F;
            endcase
            send(b);
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
                if ($urandom_range(0, 1) == 1) send(rand_invalid());
                else quiet();
            end
        end
        quiet();
        push_model();
    endtask

    initial begin
        int r0, n;

        repeat (3) @(negedge clk);
        check("rst_req", int'(cfg_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_terr", int'(timeout_err), 0);
        check("rst_delay", int'(cfg_delay), 7998);
        check("rst_atten", int'(cfg_atten), 32767);

        push_model();
        rst_n = 1'b1;
        wait_idle("init_push", 200);
        check("init_rises", req_rises, 1);

        burst(8'h11, 1);
        wait_idle("dly_inc", 200);
        check("dly_8998", int'(cfg_delay), 8998);
        burst(8'h11, 9);
        wait_idle("dly_sat", 200);
        check("dly_16382", int'(cfg_delay), 16382);
        burst(8'h12, 1);
        wait_idle("dly_dec", 200);
        check("dly_15382", int'(cfg_delay), 15382);

        burst(8'h1A, 1638);
        wait_idle("att_dec", 400);
        check("att_7", int'(cfg_atten), 7);
        burst(8'h1A, 1);
        wait_idle("att_floor", 200);
        check("att_0", int'(cfg_atten), 0);

        burst(8'h1F, 1);
        wait_idle("defaults", 200);
        ack_delay = 100;
        r0 = req_rises;
        send(8'h19);
        quiet();
        wait_req("coal_req", 20);
        for (int i = 0; i < 5; i++) send(8'h19);
        quiet();
        push_model();
        wait_idle("coalesce", 2000);
        check("coal_rises", req_rises - r0, 2);
        check("coal_atten", int'(cfg_atten), 32767);
        ack_delay = 4;

        ack_stuck = 1'b1;
        burst(8'h11, 1);
        wait_req("tmo_req", 20);
        n = 1;
        while (n < 70000) begin
            @(negedge clk);
            if (!cfg_req) break;
            n++;
        end
        check("tmo_req_cycles", n, 65536);
        wait_idle("tmo_idle", 100);
        check("tmo_err_set", int'(timeout_err), 1);
        ack_stuck = 1'b0;

        for (int i = 0; i < 20; i++) begin
            rand_burst($urandom_range(1, 30));
            wait_idle("rand_burst", 3000);
        end
        check("tmo_err_sticky", int'(timeout_err), 1);

        ack_delay = 40;
        send(8'h1F);
        send(8'h11);
        quiet();
        n = 0;
        while (!(cfg_req && cfg_delay == 15'd8998) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_req_delay", int'(cfg_delay), 8998);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_drop", int'(cfg_req), 0);
        check("rst_terr_clear", int'(timeout_err), 0);
        m_delay = 7998;
        m_atten = 32767;
        ack_delay = 4;
        repeat (3) @(negedge clk);
        push_model();
        rst_n = 1'b1;
        wait_idle("post_rst", 300);
        check("post_rst_delay", int'(cfg_delay), 7998);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
